// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci scheduler: ALU opcodes, register
// file indices and the scheduler state encoding.
package fibo_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_PASS = 3'b100;

   // Register map: R0=a, R1=b, R2=count, R3=tmp
   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;
   localparam logic [1:0] R3 = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_LD_N = 4'd1,
      ST_LD_A = 4'd2,
      ST_LD_B = 4'd3,
      ST_TST  = 4'd4,
      ST_CHK  = 4'd5,
      ST_ADD  = 4'd6,
      ST_MV_A = 4'd7,
      ST_MV_B = 4'd8,
      ST_DEC  = 4'd9,
      ST_RD   = 4'd10,
      ST_ERR  = 4'd11,
      ST_RESP = 4'd12
   } state_t;

endpackage

// File: rtl/fibo_sched_deco.sv
// Combinational decoder from scheduler state and captured N to the
// datapath control word. Fields not used by a state are driven to 0.
module fibo_sched_deco
   import fibo_pkg::*;
#(
   parameter int DW = 8,
   parameter int NW = 4
) (
   input  state_t        state,
   input  logic [NW-1:0] n,
   output logic [2:0]    alu_opcode,
   output logic [1:0]    rd_addr1,
   output logic [1:0]    rd_addr2,
   output logic [1:0]    wrt_addr,
   output logic          wrt_en,
   output logic          load_data,
   output logic [DW-1:0] load_value
);

   // Map each state onto its ALU operation, operand addresses and write control
   always_comb begin
      alu_opcode = OP_NOP;
      rd_addr1   = R0;
      rd_addr2   = R0;
      wrt_addr   = R0;
      wrt_en     = 1'b0;
      load_data  = 1'b0;
      load_value = {DW{1'b0}};
      case (state)
         ST_LD_N: begin
            alu_opcode = OP_LOAD;
            wrt_addr   = R2;
            wrt_en     = 1'b1;
            load_data  = 1'b1;
            load_value = {{(DW-NW){1'b0}}, n};
         end
         ST_LD_A: begin
            alu_opcode = OP_LOAD;
            wrt_addr   = R0;
            wrt_en     = 1'b1;
            load_data  = 1'b1;
            load_value = {DW{1'b0}};
         end
         ST_LD_B: begin
            alu_opcode = OP_LOAD;
            wrt_addr   = R1;
            wrt_en     = 1'b1;
            load_data  = 1'b1;
            load_value = {{(DW-1){1'b0}}, 1'b1};
         end
         // Rewrite count onto itself purely to refresh ZERO_FLAG
         ST_TST: begin
            alu_opcode = OP_PASS;
            rd_addr1   = R2;
            wrt_addr   = R2;
            wrt_en     = 1'b1;
         end
         ST_ADD: begin
            alu_opcode = OP_ADD;
            rd_addr1   = R0;
            rd_addr2   = R1;
            wrt_addr   = R3;
            wrt_en     = 1'b1;
         end
         ST_MV_A: begin
            alu_opcode = OP_PASS;
            rd_addr1   = R1;
            wrt_addr   = R0;
            wrt_en     = 1'b1;
         end
         ST_MV_B: begin
            alu_opcode = OP_PASS;
            rd_addr1   = R3;
            wrt_addr   = R1;
            wrt_en     = 1'b1;
         end
         ST_DEC: begin
            alu_opcode = OP_DEC;
            rd_addr1   = R2;
            wrt_addr   = R2;
            wrt_en     = 1'b1;
         end
         // Present a on the ALU output without writing so it can be captured
         ST_RD: begin
            alu_opcode = OP_PASS;
            rd_addr1   = R0;
         end
         default: begin
            alu_opcode = OP_NOP;
         end
      endcase
   end

endmodule

// File: rtl/fibo_sched.sv
// Request/response scheduler computing F(N) on a shared register file and
// ALU. Holds the state register, captured N, result register and the
// valid/ready handshakes; the control word comes from fibo_sched_deco.
// While RST is high every output is forced to 0.
module fibo_sched
   import fibo_pkg::*;
#(
   parameter int DW    = 8,
   parameter int NW    = 4,
   parameter int N_MAX = 13
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [NW-1:0] req_n,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_data,
   output logic          resp_err,
   output logic          busy,
   input  logic          ZERO_FLAG,
   input  logic [DW-1:0] alu_result,
   output logic [2:0]    alu_opcode,
   output logic [1:0]    rd_addr1,
   output logic [1:0]    rd_addr2,
   output logic [1:0]    wrt_addr,
   output logic          wrt_en,
   output logic          load_data,
   output logic [DW-1:0] load_value
);

   localparam logic [NW:0] N_LIMIT = (NW+1)'(N_MAX);

   state_t        state_r;
   state_t        state_nxt_s;
   logic [NW-1:0] n_r;
   logic [DW-1:0] resp_data_r;
   logic          resp_err_r;
   logic          accept_s;
   logic          too_big_s;
   logic          req_ready_s;
   logic          resp_valid_s;
   logic          busy_s;
   logic [2:0]    alu_opcode_s;
   logic [1:0]    rd_addr1_s;
   logic [1:0]    rd_addr2_s;
   logic [1:0]    wrt_addr_s;
   logic          wrt_en_s;
   logic          load_data_s;
   logic [DW-1:0] load_value_s;

   assign accept_s  = (state_r == ST_IDLE) & req_valid;
   assign too_big_s = ({1'b0, req_n} > N_LIMIT);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state sequencing: setup, loop on ZERO_FLAG, read-out, response
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               if (too_big_s) begin
                  state_nxt_s = ST_ERR;
               end else begin
                  state_nxt_s = ST_LD_N;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LD_N: state_nxt_s = ST_LD_A;
         ST_LD_A: state_nxt_s = ST_LD_B;
         ST_LD_B: state_nxt_s = ST_TST;
         ST_TST:  state_nxt_s = ST_CHK;
         ST_CHK: begin
            if (ZERO_FLAG) begin
               state_nxt_s = ST_RD;
            end else begin
               state_nxt_s = ST_ADD;
            end
         end
         ST_ADD:  state_nxt_s = ST_MV_A;
         ST_MV_A: state_nxt_s = ST_MV_B;
         ST_MV_B: state_nxt_s = ST_DEC;
         ST_DEC:  state_nxt_s = ST_CHK;
         ST_RD:   state_nxt_s = ST_RESP;
         ST_ERR:  state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture the requested index when a request is accepted
   always_ff @(posedge CLK) begin
      if (RST) begin
         n_r <= {NW{1'b0}};
      end else if (accept_s) begin
         n_r <= req_n;
      end else begin
         n_r <= n_r;
      end
   end

   // Result and error registers; held constant for the whole RESP state
   always_ff @(posedge CLK) begin
      if (RST) begin
         resp_data_r <= {DW{1'b0}};
         resp_err_r  <= 1'b0;
      end else if (state_r == ST_RD) begin
         resp_data_r <= alu_result;
         resp_err_r  <= 1'b0;
      end else if (state_r == ST_ERR) begin
         resp_data_r <= {DW{1'b0}};
         resp_err_r  <= 1'b1;
      end else if ((state_r == ST_RESP) && resp_ready) begin
         resp_data_r <= resp_data_r;
         resp_err_r  <= 1'b0;
      end else begin
         resp_data_r <= resp_data_r;
         resp_err_r  <= resp_err_r;
      end
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      busy_s       = 1'b1;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
            busy_s      = 1'b0;
         end
         ST_RESP: resp_valid_s = 1'b1;
         default: busy_s = 1'b1;
      endcase
   end

   fibo_sched_deco #(
      .DW (DW),
      .NW (NW)
   ) u_deco (
      .state      (state_r),
      .n          (n_r),
      .alu_opcode (alu_opcode_s),
      .rd_addr1   (rd_addr1_s),
      .rd_addr2   (rd_addr2_s),
      .wrt_addr   (wrt_addr_s),
      .wrt_en     (wrt_en_s),
      .load_data  (load_data_s),
      .load_value (load_value_s)
   );

   // Outputs are silenced for as long as reset is asserted
   assign req_ready  = req_ready_s  & ~RST;
   assign resp_valid = resp_valid_s & ~RST;
   assign busy       = busy_s       & ~RST;
   assign resp_err   = resp_err_r   & ~RST;
   assign wrt_en     = wrt_en_s     & ~RST;
   assign load_data  = load_data_s  & ~RST;
   assign resp_data  = RST ? {DW{1'b0}} : resp_data_r;
   assign alu_opcode = RST ? OP_NOP     : alu_opcode_s;
   assign rd_addr1   = RST ? R0         : rd_addr1_s;
   assign rd_addr2   = RST ? R0         : rd_addr2_s;
   assign wrt_addr   = RST ? R0         : wrt_addr_s;
   assign load_value = RST ? {DW{1'b0}} : load_value_s;

endmodule

// File: tb/tb_fibo_sched.sv
// Bench for fibo_sched: behavioural register file / ALU with a registered
// zero flag, a table of requests, a scoreboard of expected responses and
// hand-written backpressure and mid-operation reset sequences.
module tb_fibo_sched;
   import fibo_pkg::*;

   localparam int DW = 8;
   localparam int NW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [NW-1:0] req_n = 4'd0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_data;
   logic          resp_err;
   logic          busy;
   logic          ZERO_FLAG;
   logic [DW-1:0] alu_result;
   logic [2:0]    alu_opcode;
   logic [1:0]    rd_addr1, rd_addr2, wrt_addr;
   logic          wrt_en, load_data;
   logic [DW-1:0] load_value;

   fibo_sched #(.DW(DW), .NW(NW), .N_MAX(13)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_n      (req_n),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .ZERO_FLAG  (ZERO_FLAG),
      .alu_result (alu_result),
      .alu_opcode (alu_opcode),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .wrt_addr   (wrt_addr),
      .wrt_en     (wrt_en),
      .load_data  (load_data),
      .load_value (load_value)
   );

   always #5 CLK = ~CLK;

   // Behavioural datapath
   logic [DW-1:0] rf [4];
   logic [DW-1:0] wd;
   logic          zflag = 1'b0;
   int            wr_count = 0;
   int            cyc = 0;

   assign ZERO_FLAG = zflag;

   always_comb begin
      case (alu_opcode)
         3'b001:  alu_result = load_value;
         3'b010:  alu_result = rf[rd_addr1] + rf[rd_addr2];
         3'b011:  alu_result = rf[rd_addr1] - 8'd1;
         3'b100:  alu_result = rf[rd_addr1];
         default: alu_result = 8'd0;
      endcase
      wd = load_data ? load_value : alu_result;
   end

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RST) begin
         zflag <= 1'b0;
      end else if (wrt_en) begin
         rf[wrt_addr] <= wd;
         zflag        <= (wd == 8'd0);
         wr_count     <= wr_count + 1;
      end
   end

   // Checking infrastructure
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [NW-1:0] n;
      logic [DW-1:0] data;
      logic          err;
      int            lat;
      int            hold;
      bit            pulse;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {11'd0, req_ready, resp_valid, resp_err, busy, alu_opcode,
              rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data}
             | {24'd0, resp_data} | {24'd0, load_value};
   endfunction

   // One full request/response transaction with optional backpressure/pulses
   task automatic run_req(input vec_t v);
      int   acc;
      int   lat;
      int   wr_base;
      bit   got;
      exp_t e;
      @(negedge CLK);
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_n     = v.n;
      e.data    = v.data;
      e.err     = v.err;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      acc       = cyc;
      wr_base   = wr_count;
      req_valid = 1'b0;
      resp_ready = 1'b0;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 200) begin
         @(negedge CLK);
         lat = cyc - acc + 1;
         req_valid = 1'b0;
         if (resp_valid) begin
            got = 1'b1;
         end else if (v.pulse && (lat == 3 || lat == 10)) begin
            chk("ready_low_busy", 32'(req_ready), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
            req_valid = 1'b1;
            req_n     = 4'd3;
         end
      end
      req_valid = 1'b0;
      if (!got) begin
         chk("resp_timeout", 32'(resp_valid), 32'd1);
         return;
      end
      chk("resp_latency", 32'(lat), 32'(v.lat));
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("resp_data", 32'(resp_data), 32'(e.data));
      chk("resp_err", 32'(resp_err), 32'(e.err));
      chk("datapath_writes", 32'(wr_count - wr_base),
          v.err ? 32'd0 : 32'(4 + 4 * int'(v.n)));
      for (int h = 0; h < v.hold; h++) begin
         @(negedge CLK);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_data", 32'(resp_data), 32'(e.data));
         chk("hold_err", 32'(resp_err), 32'(e.err));
      end
      chk("ready_low_at_handshake", 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      @(posedge CLK);
      #1;
      resp_ready = 1'b0;
      @(negedge CLK);
      chk("ready_after_handshake", 32'(req_ready), 32'd1);
      chk("valid_after_handshake", 32'(resp_valid), 32'd0);
      chk("err_cleared", 32'(resp_err), 32'd0);
   endtask

   initial begin
      int   seen;
      vec_t v7;
      tbl[0] = '{n: 4'd0,  data: 8'd0,   err: 1'b0, lat: 7,  hold: 0,  pulse: 1'b0};
      tbl[1] = '{n: 4'd1,  data: 8'd1,   err: 1'b0, lat: 12, hold: 0,  pulse: 1'b0};
      tbl[2] = '{n: 4'd10, data: 8'd55,  err: 1'b0, lat: 57, hold: 0,  pulse: 1'b0};
      tbl[3] = '{n: 4'd13, data: 8'd233, err: 1'b0, lat: 72, hold: 0,  pulse: 1'b0};
      tbl[4] = '{n: 4'd14, data: 8'd0,   err: 1'b1, lat: 2,  hold: 3,  pulse: 1'b0};
      tbl[5] = '{n: 4'd15, data: 8'd0,   err: 1'b1, lat: 2,  hold: 0,  pulse: 1'b0};
      tbl[6] = '{n: 4'd5,  data: 8'd5,   err: 1'b0, lat: 32, hold: 20, pulse: 1'b1};
      tbl[7] = '{n: 4'd2,  data: 8'd1,   err: 1'b0, lat: 17, hold: 0,  pulse: 1'b0};
      tbl[8] = '{n: 4'd6,  data: 8'd8,   err: 1'b0, lat: 37, hold: 2,  pulse: 1'b1};
      v7     = '{n: 4'd7,  data: 8'd13,  err: 1'b0, lat: 42, hold: 0,  pulse: 1'b0};

      // Reset state
      repeat (3) begin
         @(negedge CLK);
         chk("reset_outputs_zero", all_outs(), 32'd0);
      end
      RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
      chk("busy_after_reset", 32'(busy), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_req(tbl[i]);
      end

      // Reset in the middle of an N=12 computation
      @(negedge CLK);
      req_valid = 1'b1;
      req_n     = 4'd12;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      repeat (20) @(negedge CLK);
      chk("busy_before_abort", 32'(busy), 32'd1);
      RST = 1'b1;
      #1;
      chk("abort_outputs_zero", all_outs(), 32'd0);
      repeat (2) begin
         @(negedge CLK);
         chk("abort_outputs_zero_held", all_outs(), 32'd0);
      end
      RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_abort", 32'(req_ready), 32'd1);
      resp_ready = 1'b1;
      seen = 0;
      repeat (60) begin
         @(negedge CLK);
         if (resp_valid) seen++;
      end
      resp_ready = 1'b0;
      chk("no_resp_after_abort", 32'(seen), 32'd0);
      run_req(v7);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
